// File: rtl/rtl_receiver.sv
`default_nettype none
// ============================================================================
// Module   : rtl_receiver
// Brief    : 8N1 UART receiver, 16x oversampled mid-bit sampling, with a
//            ready/read handshake and sticky framing-error / overrun flags.
// Revision : 1.0
// ============================================================================
module rtl_receiver #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_100mhz,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rd,
    output logic [7:0] data,
    output logic       rdy,
    output logic       ferr,
    output logic       ovf
);

    localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] C_DIV_LAST     = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  C_OS_LAST      = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  C_OS_HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             sync1_q;
    logic             rxd_s_q;
    logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [OS_W-1:0]  samp_cnt_q, samp_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       data_q, data_d;
    logic             rdy_q, rdy_d;
    logic             ferr_q, ferr_d;
    logic             ovf_q, ovf_d;

    logic w_tick;
    logic w_mid_start;
    logic w_bit_end;

    assign w_tick      = (tick_cnt_q == C_DIV_LAST);
    assign w_mid_start = w_tick && (samp_cnt_q == C_OS_HALF_LAST);
    assign w_bit_end   = w_tick && (samp_cnt_q == C_OS_LAST);

    // State and datapath registers; synchronizer resets to the idle line level
    always_ff @(posedge clk_100mhz or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            sync1_q    <= 1'b1;
            rxd_s_q    <= 1'b1;
            tick_cnt_q <= '0;
            samp_cnt_q <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            rdy_q      <= 1'b0;
            ferr_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= rxd;
            rxd_s_q    <= sync1_q;
            tick_cnt_q <= tick_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            rdy_q      <= rdy_d;
            ferr_q     <= ferr_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!rxd_s_q) state_d = ST_START;
            end
            ST_START: begin
                if (w_mid_start) state_d = rxd_s_q ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_end && (bit_idx_q == 3'd7)) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (w_bit_end) state_d = rxd_s_q ? ST_IDLE : ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (rxd_s_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tick_cnt_d = w_tick ? '0 : tick_cnt_q + DIV_W'(1);
        samp_cnt_d = samp_cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        rdy_d      = rdy_q;
        ferr_d     = ferr_q;
        ovf_d      = ovf_q;

        if (rd && rdy_q) begin
            rdy_d = 1'b0;
            ovf_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // Restart the tick phase at the start edge so samples land mid-bit
                if (!rxd_s_q) begin
                    tick_cnt_d = '0;
                    samp_cnt_d = '0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (samp_cnt_q == C_OS_HALF_LAST) begin
                        samp_cnt_d = '0;
                        bit_idx_d  = '0;
                    end else begin
                        samp_cnt_d = samp_cnt_q + OS_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (samp_cnt_q == C_OS_LAST) begin
                        samp_cnt_d = '0;
                        shreg_d    = {rxd_s_q, shreg_q[7:1]};
                        bit_idx_d  = bit_idx_q + 3'd1;
                    end else begin
                        samp_cnt_d = samp_cnt_q + OS_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (samp_cnt_q == C_OS_LAST) begin
                        samp_cnt_d = '0;
                        if (rxd_s_q) begin
                            // A completing byte beats a simultaneous read
                            data_d = shreg_q;
                            rdy_d  = 1'b1;
                            ferr_d = 1'b0;
                            if (rdy_q && !rd) ovf_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        samp_cnt_d = samp_cnt_q + OS_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        data = data_q;
        rdy  = rdy_q;
        ferr = ferr_q;
        ovf  = ovf_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_rtl_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtl_receiver
// Brief    : Directed self-checking bench for rtl_receiver (4 clocks per tick).
// Revision : 1.0
// ============================================================================
module tb_rtl_receiver;

    localparam int CLK_FREQ = 100_000_000;
    localparam int BAUD     = 1_562_500;
    localparam int OS       = 16;
    localparam int BIT      = 64;                 // OS * (CLK_FREQ/(BAUD*OS)) = 16*4
    localparam int LAT      = 3 + (BIT * 19) / 2; // start edge to rdy, in cycles

    logic       clk_100mhz = 1'b0;
    logic       reset      = 1'b0;
    logic       rxd        = 1'b1;
    logic       rd         = 1'b0;
    logic [7:0] data;
    logic       rdy;
    logic       ferr;
    logic       ovf;

    int n_chk  = 0;
    int n_pass = 0;

    rtl_receiver #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .rxd        (rxd),
        .rd         (rd),
        .data       (data),
        .rdy        (rdy),
        .ferr       (ferr),
        .ovf        (ovf)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    // Keeps the bench phase at 1 time unit after a rising edge
    task automatic wait_cyc(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk_100mhz);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input int stop_bits, input int gap);
        rxd = 1'b0;
        wait_cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_cyc(BIT);
        end
        rxd = stop_v;
        wait_cyc(BIT * stop_bits);
        rxd = 1'b1;
        wait_cyc(gap);
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        wait_cyc(1);
        rd = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_chk++;
        if ({data, rdy, ferr, ovf} !== 11'h000)
            $display("FAIL reset_async got data=%h rdy=%b ferr=%b ovf=%b exp all 0", data, rdy, ferr, ovf);
        else n_pass++;
        wait_cyc(5);
        reset = 1'b1;
        wait_cyc(5);
        n_chk++;
        if ({data, rdy, ferr, ovf} !== 11'h000)
            $display("FAIL reset_release got data=%h rdy=%b ferr=%b ovf=%b exp all 0", data, rdy, ferr, ovf);
        else n_pass++;
    endtask

    task automatic test_first_frame();
        int cnt;
        cnt = 0;
        fork
            send_frame(8'hA5, 1'b1, 1, 8);
            begin
                while (rdy !== 1'b1 && cnt < 2000) begin
                    wait_cyc(1);
                    cnt++;
                end
            end
        join
        n_chk++;
        if (cnt < LAT - 3 || cnt > LAT + 3)
            $display("FAIL a5_latency got %0d cycles exp %0d +/-3", cnt, LAT);
        else n_pass++;
        n_chk++;
        if (data !== 8'hA5) $display("FAIL a5_data got %h exp a5", data);
        else n_pass++;
        n_chk++;
        if ({rdy, ferr, ovf} !== 3'b100)
            $display("FAIL a5_flags got rdy/ferr/ovf=%b exp 100", {rdy, ferr, ovf});
        else n_pass++;
    endtask

    task automatic test_glitch();
        rxd = 1'b0;
        wait_cyc(20);
        rxd = 1'b1;
        wait_cyc(200);
        n_chk++;
        if (data !== 8'hA5 || {rdy, ferr, ovf} !== 3'b100)
            $display("FAIL glitch got data=%h rdy/ferr/ovf=%b exp a5 100", data, {rdy, ferr, ovf});
        else n_pass++;
    endtask

    task automatic test_read();
        pulse_rd();
        n_chk++;
        if (rdy !== 1'b0 || data !== 8'hA5)
            $display("FAIL read_clear got rdy=%b data=%h exp 0 a5", rdy, data);
        else n_pass++;
        pulse_rd();
        n_chk++;
        if ({rdy, ferr, ovf} !== 3'b000 || data !== 8'hA5)
            $display("FAIL read_idle got rdy/ferr/ovf=%b data=%h exp 000 a5", {rdy, ferr, ovf}, data);
        else n_pass++;
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 1'b0, 2, 8);
        n_chk++;
        if ({rdy, ferr, ovf} !== 3'b010 || data !== 8'hA5)
            $display("FAIL ferr_set got rdy/ferr/ovf=%b data=%h exp 010 a5", {rdy, ferr, ovf}, data);
        else n_pass++;
        pulse_rd();
        n_chk++;
        if (ferr !== 1'b1) $display("FAIL ferr_sticky got %b exp 1", ferr);
        else n_pass++;
        send_frame(8'h3C, 1'b1, 1, 8);
        n_chk++;
        if (data !== 8'h3C || {rdy, ferr, ovf} !== 3'b100)
            $display("FAIL ferr_recover got data=%h rdy/ferr/ovf=%b exp 3c 100", data, {rdy, ferr, ovf});
        else n_pass++;
        pulse_rd();
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1, 1, 8);
        send_frame(8'h22, 1'b1, 1, 8);
        n_chk++;
        if (data !== 8'h22 || {rdy, ovf} !== 2'b11)
            $display("FAIL ovf_set got data=%h rdy/ovf=%b exp 22 11", data, {rdy, ovf});
        else n_pass++;
        pulse_rd();
        n_chk++;
        if ({rdy, ovf} !== 2'b00) $display("FAIL ovf_clear got rdy/ovf=%b exp 00", {rdy, ovf});
        else n_pass++;
        send_frame(8'h11, 1'b1, 1, 8);
        n_chk++;
        if (data !== 8'h11 || {rdy, ovf} !== 2'b10)
            $display("FAIL ovf_first got data=%h rdy/ovf=%b exp 11 10", data, {rdy, ovf});
        else n_pass++;
        fork
            send_frame(8'h22, 1'b1, 1, 8);
            begin
                wait_cyc(LAT - 1);
                rd = 1'b1;
                wait_cyc(1);
                rd = 1'b0;
                n_chk++;
                if (data !== 8'h22 || {rdy, ovf} !== 2'b10)
                    $display("FAIL ovf_rd_same got data=%h rdy/ovf=%b exp 22 10", data, {rdy, ovf});
                else n_pass++;
            end
        join
        n_chk++;
        if ({rdy, ovf} !== 2'b10) $display("FAIL ovf_rd_after got rdy/ovf=%b exp 10", {rdy, ovf});
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        send_frame(8'hC3, 1'b1, 1, 8);
        fork
            send_frame(8'hFF, 1'b1, 1, 8);
            begin
                wait_cyc(BIT * 5 + BIT / 2);
                reset = 1'b0;
                #1;
                n_chk++;
                if ({data, rdy, ferr, ovf} !== 11'h000)
                    $display("FAIL mid_reset got data=%h rdy/ferr/ovf=%b exp all 0", data, {rdy, ferr, ovf});
                else n_pass++;
                wait_cyc(10);
                reset = 1'b1;
            end
        join
        n_chk++;
        if ({data, rdy, ferr, ovf} !== 11'h000)
            $display("FAIL mid_reset_hold got data=%h rdy/ferr/ovf=%b exp all 0", data, {rdy, ferr, ovf});
        else n_pass++;
        send_frame(8'h5A, 1'b1, 1, 8);
        n_chk++;
        if (data !== 8'h5A || {rdy, ferr, ovf} !== 3'b100)
            $display("FAIL post_reset got data=%h rdy/ferr/ovf=%b exp 5a 100", data, {rdy, ferr, ovf});
        else n_pass++;
        pulse_rd();
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        for (int i = 0; i < 25; i++) begin
            if (i == 0)      b = 8'h81;
            else if (i < 17) b = 8'((i - 1) * 17);
            else             b = 8'(1 << (i - 17));
            send_frame(b, 1'b1, 1, 0);
            n_chk++;
            if (data !== b || rdy !== 1'b1)
                $display("FAIL b2b_byte%0d got data=%h rdy=%b exp %h 1", i, data, rdy, b);
            else n_pass++;
            pulse_rd();
            n_chk++;
            if (rdy !== 1'b0) $display("FAIL b2b_read%0d got rdy=%b exp 0", i, rdy);
            else n_pass++;
        end
        n_chk++;
        if ({ferr, ovf} !== 2'b00) $display("FAIL b2b_flags got ferr/ovf=%b exp 00", {ferr, ovf});
        else n_pass++;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog timeout got no finish exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_first_frame();
        test_glitch();
        test_read();
        test_framing();
        test_overrun();
        test_reset_midframe();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
